// File: rtl/rx_commit_pkg.sv
// Shared types and constants for the RX frame commit controller.
package rx_commit_pkg;

    localparam int unsigned LEN_W = 11;

    typedef enum logic [1:0] {IDLE, WRITE, CHECK, DISCARD} commit_state_t;
    typedef enum logic [1:0] {NONE, ERR, OVF, LONG} drop_reason_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: increments on inc and holds at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rx_frame_commit_ctrl.sv
// Write-side RX buffer controller: streams frames into a circular RAM, then commits each one
// or rewinds the write pointer once its verdict window closes.
module rx_frame_commit_ctrl
    import rx_commit_pkg::*;
#(
    parameter int unsigned ADDR_W       = 11,
    parameter int unsigned MIN_LEN      = 64,
    parameter int unsigned MAX_LEN      = 1518,
    parameter int unsigned CHECK_CYCLES = 4,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    input  logic              error_pulse_i,
    input  logic [ADDR_W:0]   rd_ptr_i,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_waddr_o,
    output logic [7:0]        ram_wdata_o,
    output logic [ADDR_W:0]   commit_ptr_o,
    output logic              commit_pulse_o,
    output logic [LEN_W-1:0]  commit_len_o,
    output logic [CNT_W-1:0]  cnt_ok_o,
    output logic [CNT_W-1:0]  cnt_err_o,
    output logic [CNT_W-1:0]  cnt_ovf_o,
    output logic [CNT_W-1:0]  cnt_long_o,
    output logic [CNT_W-1:0]  cnt_runt_o
);

    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam int unsigned TMR_W = 3;
    localparam logic [PTR_W-1:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(CHECK_CYCLES - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(MIN_LEN);

    commit_state_t      state_q, state_d;
    drop_reason_t       reason_q, reason_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   commit_ptr_q, commit_ptr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   commit_len_q, commit_len_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               commit_pulse_q, commit_pulse_d;
    logic               inc_ok, inc_err, inc_ovf, inc_long, inc_runt;
    logic [PTR_W-1:0]   used;
    logic               full;

    assign used = wr_ptr_q - rd_ptr_i;
    assign full = (used == DEPTH);

    assign ram_waddr_o    = wr_ptr_q[ADDR_W-1:0];
    assign ram_wdata_o    = rx_data_i;
    assign commit_ptr_o   = commit_ptr_q;
    assign commit_pulse_o = commit_pulse_q;
    assign commit_len_o   = commit_len_q;

    always_comb begin
        state_d        = state_q;
        reason_d       = reason_q;
        wr_ptr_d       = wr_ptr_q;
        commit_ptr_d   = commit_ptr_q;
        len_d          = len_q;
        commit_len_d   = commit_len_q;
        timer_d        = timer_q;
        commit_pulse_d = 1'b0;
        ram_we_o       = 1'b0;
        inc_ok         = 1'b0;
        inc_err        = 1'b0;
        inc_ovf        = 1'b0;
        inc_long       = 1'b0;
        inc_runt       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_valid_i) begin
                    if (error_pulse_i) begin
                        state_d  = DISCARD;
                        reason_d = ERR;
                    end else if (full) begin
                        state_d  = DISCARD;
                        reason_d = OVF;
                    end else begin
                        ram_we_o = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        len_d    = LEN_W'(1);
                        state_d  = WRITE;
                    end
                end
            end
            WRITE: begin
                if (rx_valid_i) begin
                    if (error_pulse_i || full || (len_q == LEN_MAX)) begin
                        wr_ptr_d = commit_ptr_q;
                        state_d  = DISCARD;
                        reason_d = error_pulse_i ? ERR : (full ? OVF : LONG);
                    end else begin
                        ram_we_o = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        len_d    = len_q + LEN_W'(1);
                    end
                end else if (error_pulse_i) begin
                    wr_ptr_d = commit_ptr_q;
                    inc_err  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    timer_d = TMR_INIT;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (error_pulse_i) begin
                    wr_ptr_d = commit_ptr_q;
                    inc_err  = 1'b1;
                    state_d  = IDLE;
                end else if ((timer_q == '0) || rx_valid_i) begin
                    // An early next frame closes the verdict window immediately.
                    if (len_q < LEN_MIN) begin
                        wr_ptr_d = commit_ptr_q;
                        inc_runt = 1'b1;
                    end else begin
                        commit_ptr_d   = wr_ptr_q;
                        commit_len_d   = len_q;
                        commit_pulse_d = 1'b1;
                        inc_ok         = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
                if (rx_valid_i) begin
                    state_d  = DISCARD;
                    reason_d = ERR;
                end
            end
            DISCARD: begin
                if (!rx_valid_i) begin
                    inc_err  = (reason_q == ERR);
                    inc_ovf  = (reason_q == OVF);
                    inc_long = (reason_q == LONG);
                    reason_d = NONE;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= DISCARD;
            reason_q       <= NONE;
            wr_ptr_q       <= '0;
            commit_ptr_q   <= '0;
            len_q          <= '0;
            commit_len_q   <= '0;
            timer_q        <= '0;
            commit_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            reason_q       <= reason_d;
            wr_ptr_q       <= wr_ptr_d;
            commit_ptr_q   <= commit_ptr_d;
            len_q          <= len_d;
            commit_len_q   <= commit_len_d;
            timer_q        <= timer_d;
            commit_pulse_q <= commit_pulse_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt_ok   (.clk(clk), .rst_n(rst_n), .inc(inc_ok),   .q(cnt_ok_o));
    sat_counter #(.CNT_W(CNT_W)) u_cnt_err  (.clk(clk), .rst_n(rst_n), .inc(inc_err),  .q(cnt_err_o));
    sat_counter #(.CNT_W(CNT_W)) u_cnt_ovf  (.clk(clk), .rst_n(rst_n), .inc(inc_ovf),  .q(cnt_ovf_o));
    sat_counter #(.CNT_W(CNT_W)) u_cnt_long (.clk(clk), .rst_n(rst_n), .inc(inc_long), .q(cnt_long_o));
    sat_counter #(.CNT_W(CNT_W)) u_cnt_runt (.clk(clk), .rst_n(rst_n), .inc(inc_runt), .q(cnt_runt_o));

endmodule

// File: tb/tb_rx_frame_commit_ctrl.sv
// Directed bench: a default-sized instance plus a 64-byte-buffer instance for the full cases.
module tb_rx_frame_commit_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rx_valid, error_pulse, sel_small;
    logic [7:0] rx_data;
    logic       valid_a, valid_b, err_a, err_b;
    logic [11:0] rd_ptr_a;
    logic [6:0]  rd_ptr_b;

    assign valid_a = rx_valid & ~sel_small;
    assign valid_b = rx_valid & sel_small;
    assign err_a   = error_pulse & ~sel_small;
    assign err_b   = error_pulse & sel_small;

    logic        a_we, a_pulse;
    logic [10:0] a_waddr, a_clen;
    logic [7:0]  a_wdata;
    logic [11:0] a_cptr;
    logic [31:0] a_ok, a_err, a_ovf, a_long, a_runt;

    logic        b_we, b_pulse;
    logic [5:0]  b_waddr;
    logic [10:0] b_clen;
    logic [7:0]  b_wdata;
    logic [6:0]  b_cptr;
    logic [31:0] b_ok, b_err, b_ovf, b_long, b_runt;

    rx_frame_commit_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .rx_valid_i(valid_a), .rx_data_i(rx_data),
        .error_pulse_i(err_a), .rd_ptr_i(rd_ptr_a), .ram_we_o(a_we), .ram_waddr_o(a_waddr),
        .ram_wdata_o(a_wdata), .commit_ptr_o(a_cptr), .commit_pulse_o(a_pulse),
        .commit_len_o(a_clen), .cnt_ok_o(a_ok), .cnt_err_o(a_err), .cnt_ovf_o(a_ovf),
        .cnt_long_o(a_long), .cnt_runt_o(a_runt)
    );

    rx_frame_commit_ctrl #(.ADDR_W(6)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_valid_i(valid_b), .rx_data_i(rx_data),
        .error_pulse_i(err_b), .rd_ptr_i(rd_ptr_b), .ram_we_o(b_we), .ram_waddr_o(b_waddr),
        .ram_wdata_o(b_wdata), .commit_ptr_o(b_cptr), .commit_pulse_o(b_pulse),
        .commit_len_o(b_clen), .cnt_ok_o(b_ok), .cnt_err_o(b_err), .cnt_ovf_o(b_ovf),
        .cnt_long_o(b_long), .cnt_runt_o(b_runt)
    );

    logic        s_we, s_pulse;
    logic [10:0] s_waddr, s_clen;
    logic [7:0]  s_wdata;

    always_comb begin
        s_we    = sel_small ? b_we : a_we;
        s_pulse = sel_small ? b_pulse : a_pulse;
        s_waddr = sel_small ? {5'b0, b_waddr} : a_waddr;
        s_clen  = sel_small ? b_clen : a_clen;
        s_wdata = sel_small ? b_wdata : a_wdata;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt, first_addr, last_addr, pulse_cnt, pulse_at;
    logic [7:0]  last_wdata;
    logic [10:0] pulse_len;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Entered and left at posedge+1; outputs sampled on the falling edge.
    task automatic send_frame(input int n, input int err_at);
        wr_cnt     = 0;
        first_addr = -1;
        last_addr  = -1;
        last_wdata = '0;
        for (int i = 1; i <= n; i++) begin
            rx_valid    = 1'b1;
            rx_data     = 8'(i) ^ 8'h5A;
            error_pulse = (i == err_at);
            @(negedge clk);
            if (s_we) begin
                if (wr_cnt == 0) first_addr = int'(s_waddr);
                last_addr  = int'(s_waddr);
                last_wdata = s_wdata;
                wr_cnt++;
            end
            @(posedge clk);
            #1;
        end
        rx_valid    = 1'b0;
        error_pulse = 1'b0;
    endtask

    task automatic idle(input int n, input int err_at);
        pulse_cnt = 0;
        pulse_at  = 0;
        pulse_len = '0;
        for (int k = 1; k <= n; k++) begin
            rx_valid    = 1'b0;
            error_pulse = (k == err_at);
            @(negedge clk);
            if (s_pulse) begin
                pulse_cnt++;
                if (pulse_at == 0) begin
                    pulse_at  = k;
                    pulse_len = s_clen;
                end
            end
            @(posedge clk);
            #1;
        end
        error_pulse = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        rx_valid    = 1'b0;
        error_pulse = 1'b0;
        sel_small   = 1'b0;
        rx_data     = '0;
        rd_ptr_a    = '0;
        rd_ptr_b    = '0;
        @(posedge clk);
        #2;
        check_eq("rst_cptr", 64'(a_cptr), 0);
        check_eq("rst_pulse", 64'(a_pulse), 0);
        check_eq("rst_ok", 64'(a_ok), 0);
        check_eq("rst_we", 64'(a_we), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3, 0);

        // Error pulse inside the verdict window drops the frame.
        send_frame(100, 0);
        check_eq("t2_writes", 64'(wr_cnt), 100);
        idle(10, 3);
        check_eq("t2_pulses", 64'(pulse_cnt), 0);
        check_eq("t2_err", 64'(a_err), 1);
        check_eq("t2_cptr", 64'(a_cptr), 0);

        // Clean frame reuses addr 0; pulse is the 6th low cycle (WRITE, then timer 3..0).
        send_frame(100, 0);
        check_eq("t1_first", 64'(first_addr), 0);
        check_eq("t1_last", 64'(last_addr), 99);
        check_eq("t1_writes", 64'(wr_cnt), 100);
        check_eq("t1_wdata", 64'(last_wdata), 64'h3E);
        idle(10, 0);
        check_eq("t1_pulses", 64'(pulse_cnt), 1);
        check_eq("t1_pulse_at", 64'(pulse_at), 6);
        check_eq("t1_len", 64'(pulse_len), 100);
        check_eq("t1_cptr", 64'(a_cptr), 100);
        check_eq("t1_ok", 64'(a_ok), 1);

        // Runt.
        send_frame(40, 0);
        check_eq("t5_first", 64'(first_addr), 100);
        check_eq("t5_writes", 64'(wr_cnt), 40);
        idle(10, 0);
        check_eq("t5_pulses", 64'(pulse_cnt), 0);
        check_eq("t5_runt", 64'(a_runt), 1);
        check_eq("t5_cptr", 64'(a_cptr), 100);

        // Oversize: 1518 bytes written, byte 1519 forces the drop.
        send_frame(1519, 0);
        check_eq("t4_writes", 64'(wr_cnt), 1518);
        check_eq("t4_first", 64'(first_addr), 100);
        check_eq("t4_last", 64'(last_addr), 1617);
        idle(6, 0);
        check_eq("t4_long", 64'(a_long), 1);
        check_eq("t4_cptr", 64'(a_cptr), 100);
        check_eq("t4_pulses", 64'(pulse_cnt), 0);
        check_eq("t4_ok", 64'(a_ok), 1);

        // Small buffer: full after 64 bytes, overflow counted only when the frame ends.
        sel_small = 1'b1;
        send_frame(70, 0);
        check_eq("t3_writes", 64'(wr_cnt), 64);
        check_eq("t3_first", 64'(first_addr), 0);
        check_eq("t3_last", 64'(last_addr), 63);
        check_eq("t3_ovf_mid", 64'(b_ovf), 0);
        idle(4, 0);
        check_eq("t3_ovf", 64'(b_ovf), 1);
        check_eq("t3_cptr", 64'(b_cptr), 0);

        // Error and full on the same byte: error wins.
        send_frame(65, 65);
        check_eq("t5b_writes", 64'(wr_cnt), 64);
        idle(4, 0);
        check_eq("t5b_err", 64'(b_err), 1);
        check_eq("t5b_ovf", 64'(b_ovf), 1);
        sel_small = 1'b0;

        // Reset mid-frame, released with valid still high.
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #2;
        check_eq("t6_rst_cptr", 64'(a_cptr), 0);
        check_eq("t6_rst_ok", 64'(a_ok), 0);
        check_eq("t6_rst_we", 64'(a_we), 0);
        check_eq("t6_rst_b_ovf", 64'(b_ovf), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(10, 0);
        check_eq("t6_swallow", 64'(wr_cnt), 0);
        idle(4, 0);
        check_eq("t6_err", 64'(a_err), 0);
        check_eq("t6_runt", 64'(a_runt), 0);
        check_eq("t6_long", 64'(a_long), 0);
        check_eq("t6_pulses", 64'(pulse_cnt), 0);
        send_frame(64, 0);
        check_eq("t6_first", 64'(first_addr), 0);
        check_eq("t6_writes", 64'(wr_cnt), 64);
        check_eq("t6_wdata", 64'(last_wdata), 64'h1A);
        idle(10, 0);
        check_eq("t6_pulse_at", 64'(pulse_at), 6);
        check_eq("t6_len", 64'(pulse_len), 64);
        check_eq("t6_cptr", 64'(a_cptr), 64);
        check_eq("t6_ok", 64'(a_ok), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
